seven_segment_capture: RTL

- Receive-side counterpart of the hex-to-seven-segment encoder: watches a multiplexed, active-low seven-segment display bus and recovers the hex nibble shown on each digit.
- Used as an on-chip loopback monitor and bench observer for the display path. It exports the decoded digit values to debug logic without needing an external probe.
- Accepts a pattern only after it has been stable for a programmable dwell. Flags patterns that are not legal.

---
 rtl/seven_segment_pkg.sv | 36 +++
 rtl/seven_segment_capture_if.sv | 33 +++
 rtl/seven_segment_inverse.sv | 48 ++++
 rtl/seven_segment_capture.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// -----------------------------------------------------------------------------
// seven_segment_pkg
// Shared definitions for the seven-segment capture path:
//   - the sixteen team segment patterns, written g..a (bit6 = g, bit0 = a),
//     active-low, so a bus sample can be compared against them directly
//   - the blank pattern (all segments off)
//   - the capture state enumeration
// -----------------------------------------------------------------------------
package seven_segment_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0011000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

endpackage

// File: rtl/seven_segment_capture_if.sv
// -----------------------------------------------------------------------------
// seven_segment_capture_if
// Groups the display bus and the decoded results of the capture block.
//   seg       : active-low segment lines, bit0 = a .. bit6 = g
//   digit_sel : one-hot, active-high digit select
//   value     : decoded nibbles, digit i at [4i+3:4i]
//   valid     : per-digit "holds a legal nibble"
//   upd       : one-cycle pulse per accepted pattern
//   upd_idx   : digit index of the accepted pattern (meaningful with upd)
//   err       : sticky illegal-pattern flag
// master = display driver / observer side, slave = capture block.
// -----------------------------------------------------------------------------
interface seven_segment_capture_if #(
   parameter int NUM_DIGITS = 4
);
   logic [6:0]              seg;
   logic [NUM_DIGITS-1:0]   digit_sel;
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   valid;
   logic                    upd;
   logic [7:0]              upd_idx;
   logic                    err;

   modport master (
      output seg, digit_sel,
      input  value, valid, upd, upd_idx, err
   );

   modport slave (
      input  seg, digit_sel,
      output value, valid, upd, upd_idx, err
   );
endinterface

// File: rtl/seven_segment_inverse.sv
// -----------------------------------------------------------------------------
// seven_segment_inverse
// Combinational inverse of the team hex-to-seven-segment encoder.
//   pattern : active-low segment sample, bit0 = a .. bit6 = g
//   nibble  : decoded hex value (0 when the pattern is not a digit)
//   legal   : pattern is one of the sixteen digit patterns
//   blank   : pattern has every segment off
// -----------------------------------------------------------------------------
module seven_segment_inverse
   import seven_segment_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       legal,
   output logic       blank
);

   // Pattern lookup; anything outside the table is reported as not legal
   always_comb begin
      nibble = 4'h0;
      legal  = 1'b1;
      case (pattern)
         SEG_0:   nibble = 4'h0;
         SEG_1:   nibble = 4'h1;
         SEG_2:   nibble = 4'h2;
         SEG_3:   nibble = 4'h3;
         SEG_4:   nibble = 4'h4;
         SEG_5:   nibble = 4'h5;
         SEG_6:   nibble = 4'h6;
         SEG_7:   nibble = 4'h7;
         SEG_8:   nibble = 4'h8;
         SEG_9:   nibble = 4'h9;
         SEG_A:   nibble = 4'hA;
         SEG_B:   nibble = 4'hB;
         SEG_C:   nibble = 4'hC;
         SEG_D:   nibble = 4'hD;
         SEG_E:   nibble = 4'hE;
         SEG_F:   nibble = 4'hF;
         default: begin
            nibble = 4'h0;
            legal  = 1'b0;
         end
      endcase
   end

   assign blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/seven_segment_capture.sv
// -----------------------------------------------------------------------------
// seven_segment_capture
// Watches a multiplexed active-low seven-segment bus and recovers the nibble
// shown on each digit once the (segment, select) pair has been stable for
// STABLE_CYCLES consecutive samples. Exactly one update per dwell.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : seven_segment_capture_if.slave (seg/digit_sel in, results out)
// Parameters:
//   NUM_DIGITS    : number of multiplexed digits
//   STABLE_CYCLES : identical samples required before acceptance (1..255)
// -----------------------------------------------------------------------------
module seven_segment_capture
   import seven_segment_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
)(
   input  logic                   clk,
   input  logic                   reset,
   seven_segment_capture_if.slave bus
);

   localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

   logic [6:0]              seg_r;
   logic [NUM_DIGITS-1:0]   sel_r;
   logic [6:0]              seg_q_r;
   logic [NUM_DIGITS-1:0]   sel_q_r;
   logic [7:0]              cnt_r;
   state_t                  state_r;
   state_t                  state_s;

   logic                    chg_s;
   logic                    onehot_s;
   logic [7:0]              ones_s;
   logic [7:0]              idx_s;
   logic                    accept_s;

   logic [3:0]              nibble_s;
   logic                    legal_s;
   logic                    blank_s;

   logic [4*NUM_DIGITS-1:0] value_r;
   logic [NUM_DIGITS-1:0]   valid_r;
   logic                    upd_r;
   logic [7:0]              upd_idx_r;
   logic                    err_r;

   // Sample the bus, and keep the previous sample so a change is visible
   always_ff @(posedge clk) begin
      seg_r   <= bus.seg;
      sel_r   <= bus.digit_sel;
      seg_q_r <= seg_r;
      sel_q_r <= sel_r;
   end

   // Count edges at which the sampled pair is reloaded with an identical value;
   // after a change it reads 0 in the same cycle the new pair first appears
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= 8'd0;
      end else if ({bus.seg, bus.digit_sel} != {seg_r, sel_r}) begin
         cnt_r <= 8'd0;
      end else if (cnt_r != 8'd255) begin
         cnt_r <= cnt_r + 8'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign chg_s = ({seg_r, sel_r} != {seg_q_r, sel_q_r});

   // Population count and index of the sampled select lines
   always_comb begin
      ones_s = 8'd0;
      idx_s  = 8'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (sel_r[i]) begin
            ones_s = ones_s + 8'd1;
            idx_s  = 8'(i);
         end else begin
            ones_s = ones_s;
         end
      end
   end

   assign onehot_s = (ones_s == 8'd1);

   seven_segment_inverse u_inverse (
      .pattern (seg_r),
      .nibble  (nibble_s),
      .legal   (legal_s),
      .blank   (blank_s)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (onehot_s) begin
               state_s = SETTLE;
            end else begin
               state_s = IDLE;
            end
         end
         SETTLE: begin
            if (!onehot_s) begin
               state_s = IDLE;
            end else if (chg_s) begin
               state_s = SETTLE;
            end else if (cnt_r >= STABLE_LAST) begin
               state_s = HOLD;
            end else begin
               state_s = SETTLE;
            end
         end
         HOLD: begin
            if (!chg_s) begin
               state_s = HOLD;
            end else if (onehot_s) begin
               state_s = SETTLE;
            end else begin
               state_s = IDLE;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // FSM output logic: accept once per dwell, only from SETTLE
   always_comb begin
      accept_s = 1'b0;
      case (state_r)
         SETTLE: begin
            if (onehot_s && !chg_s && (cnt_r >= STABLE_LAST)) begin
               accept_s = 1'b1;
            end else begin
               accept_s = 1'b0;
            end
         end
         default: accept_s = 1'b0;
      endcase
   end

   // Per-digit storage and update/error outputs; reset wins over acceptance
   always_ff @(posedge clk) begin
      if (reset) begin
         value_r   <= '0;
         valid_r   <= '0;
         upd_r     <= 1'b0;
         upd_idx_r <= 8'd0;
         err_r     <= 1'b0;
      end else begin
         upd_r <= accept_s;
         if (accept_s) begin
            upd_idx_r <= idx_s;
         end else begin
            upd_idx_r <= upd_idx_r;
         end
         // Blank and illegal both invalidate the digit; only illegal is an error
         err_r <= err_r | (accept_s & ~legal_s & ~blank_s);
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (accept_s && sel_r[i]) begin
               if (legal_s) begin
                  value_r[4*i +: 4] <= nibble_s;
                  valid_r[i]        <= 1'b1;
               end else begin
                  valid_r[i]        <= 1'b0;
               end
            end
         end
      end
   end

   assign bus.value   = value_r;
   assign bus.valid   = valid_r;
   assign bus.upd     = upd_r;
   assign bus.upd_idx = upd_idx_r;
   assign bus.err     = err_r;

endmodule
